// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// The granted write is registered one cycle and decoded to one-hot enables; R0 writes are dropped.
module regfile_write_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [ADDRESS_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [BUS_WIDTH-1:0]            wr_onehot,
  output logic [15:0]                     wr_count,
  output logic [7:0]                      r0_drop_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [BUS_WIDTH-1:0]     wr_onehot_q, wr_onehot_d;
  logic [15:0]              wr_count_q, wr_count_d;
  logic [7:0]               r0_drop_count_q, r0_drop_count_d;

  logic                     grant_found;
  logic [PW-1:0]            grant_idx;
  logic [NUM_REQ-1:0]       grant_vec;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  int                       idx;

  // Handshake: a transfer happens in any cycle where req_valid[i] & req_ready[i]; ready is a
  // function of reset, hold, req_valid and rr_ptr only, so it never looks at address or data.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_vec   = '0;
    idx         = 0;
    if (!reset && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_found && req_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = PW'(idx);
        end
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  assign req_ready = grant_vec;
  assign sel_addr  = req_addr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign sel_data  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    wr_en_d         = 1'b0;
    wr_onehot_d     = '0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    wr_count_d      = wr_count_q;
    r0_drop_count_d = r0_drop_count_q;
    if (grant_found) begin
      rr_ptr_d  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      if (sel_addr != '0) begin
        wr_en_d     = 1'b1;
        wr_onehot_d = BUS_WIDTH'(1) << sel_addr;
      end else if (r0_drop_count_q != 8'hFF) begin
        r0_drop_count_d = r0_drop_count_q + 8'd1;
      end
    end
    // Counts writes as they appear on the port, one cycle after acceptance.
    if (wr_en_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_onehot_q     <= '0;
      wr_count_q      <= '0;
      r0_drop_count_q <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_onehot_q     <= wr_onehot_d;
      wr_count_q      <= wr_count_d;
      r0_drop_count_q <= r0_drop_count_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_onehot     = wr_onehot_q;
  assign wr_count      = wr_count_q;
  assign r0_drop_count = r0_drop_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, checked every cycle
// against a reference arbiter model and a queue of expected committed writes.
module tb_regfile_write_arbiter;

  localparam int N  = 2;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [BW-1:0]   wr_onehot;
  logic [15:0]     wr_count;
  logic [7:0]      r0_drop_count;

  int vectors    = 0;
  int miscompares = 0;
  logic mon_en   = 1'b0;

  logic [AW+DW-1:0] exp_q[$];
  int               m_ptr  = 0;
  logic [15:0]      m_cnt  = '0;
  logic [7:0]       m_r0   = '0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_onehot(wr_onehot), .wr_count(wr_count), .r0_drop_count(r0_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus; inputs change just after the rising edge.
  task automatic drive(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic h);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    hold      = h;
    @(posedge clk);
    #1;
  endtask

  // Reference model: checks this cycle's outputs, then advances to the next cycle.
  always @(negedge clk) begin
    logic [N-1:0]     e_ready;
    logic             e_found;
    int               g;
    logic [AW+DW-1:0] ent;
    logic             e_wen;
    logic [BW-1:0]    e_onehot;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    if (mon_en) begin
      e_ready = '0;
      e_found = 1'b0;
      g       = 0;
      if (!reset && !hold) begin
        for (int k = 0; k < N; k++) begin
          if (!e_found && req_valid[(m_ptr + k) % N]) begin
            e_found = 1'b1;
            g       = (m_ptr + k) % N;
          end
        end
      end
      if (e_found) e_ready[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(e_ready));

      e_wen    = 1'b0;
      e_onehot = '0;
      if (exp_q.size() > 0) begin
        ent    = exp_q.pop_front();
        m_addr = ent[AW+DW-1:DW];
        m_data = ent[DW-1:0];
        e_wen  = (m_addr != '0);
        if (e_wen) e_onehot[m_addr] = 1'b1;
      end
      check("wr_en", 32'(wr_en), 32'(e_wen));
      check("wr_onehot", 32'(wr_onehot), 32'(e_onehot));
      check("wr_addr", 32'(wr_addr), 32'(m_addr));
      check("wr_data", wr_data, m_data);
      check("wr_count", 32'(wr_count), 32'(m_cnt));
      check("r0_drop_count", 32'(r0_drop_count), 32'(m_r0));

      if (reset) begin
        m_ptr  = 0;
        m_cnt  = '0;
        m_r0   = '0;
        m_addr = '0;
        m_data = '0;
        exp_q.delete();
      end else begin
        if (e_wen && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (e_found) begin
          a = req_addr[g*AW +: AW];
          d = req_data[g*DW +: DW];
          exp_q.push_back({a, d});
          if (a == '0 && m_r0 != 8'hFF) m_r0 = m_r0 + 8'd1;
          m_ptr = (g + 1) % N;
        end
      end
    end
  end

  initial begin
    // Reset held two cycles with every requester valid: no grants may appear.
    reset = 1'b1;
    hold  = 1'b0;
    req_valid = '1;
    req_addr  = {3'd2, 3'd1};
    req_data  = '1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(2'b11, 3'd1, 3'd2, 32'h1111_1111, 32'h2222_2222, 1'b0);
    reset = 1'b0;

    // Single write to R5, then idle.
    drive(2'b01, 3'd5, 3'd0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    repeat (2) drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    // Fairness from a fresh pointer: both valid for four cycles.
    reset = 1'b1;
    drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(2'b11, 3'd1, 3'd2, 32'hA000_0000 + i, 32'hB000_0000 + i, 1'b0);
    repeat (2) drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    // Write to R0 from requester 1 is accepted and dropped.
    drive(2'b10, 3'd0, 3'd0, 32'h0, 32'h0BAD_0000, 1'b0);
    repeat (2) drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    // Accept a write, then hold for three cycles with requester 1 waiting.
    drive(2'b01, 3'd3, 3'd6, 32'h3333_3333, 32'h6666_6666, 1'b0);
    repeat (3) drive(2'b10, 3'd3, 3'd6, 32'h3333_3333, 32'h6666_6666, 1'b1);
    drive(2'b10, 3'd3, 3'd6, 32'h3333_3333, 32'h6666_6666, 1'b0);
    repeat (2) drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    // Back-to-back writes to the same register from both sources.
    repeat (3) drive(2'b11, 3'd7, 3'd7, $urandom, $urandom, 1'b0);

    // Random traffic with occasional hold and reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, ($urandom_range(0, 3) == 0));
    end
    reset = 1'b0;

    // Saturate wr_count with a continuous stream of writes.
    for (int i = 0; i < 65545; i++) drive(2'b01, 3'd1, 3'd0, $urandom, 32'h0, 1'b0);

    // Reset in an accept cycle: nothing commits, pointer returns to requester 0.
    reset = 1'b1;
    drive(2'b11, 3'd4, 3'd5, 32'h4444_4444, 32'h5555_5555, 1'b0);
    reset = 1'b0;
    drive(2'b11, 3'd4, 3'd5, 32'h4444_4444, 32'h5555_5555, 1'b0);
    drive(2'b11, 3'd4, 3'd5, 32'h4444_4444, 32'h5555_5555, 1'b0);
    repeat (3) drive(2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
